// File: rtl/isa_shared.sv
// Operation encodings shared between the ALU and the execute-stage blocks that borrow it.
package isa_shared;
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_ops_e;
endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier that borrows the core ALU adder for DATA_WIDTH cycles.
// Latency: DATA_WIDTH RUN cycles after accept (one cycle for a zero operand); result held until taken.
module alu_mul_seq
  import isa_shared::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] prod_lo,
  output logic [DATA_WIDTH-1:0] prod_hi,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output alu_ops_e              alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carry
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [CW-1:0]         r_count;
  logic                  w_accept;
  logic                  w_zero;
  logic                  w_last;

  assign w_accept = start_valid && start_ready;
  assign w_zero   = (op_a == '0) || (op_b == '0);
  assign w_last   = (r_count == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = w_zero ? S_DONE : S_RUN;
        S_RUN:   if (w_last) w_state_nxt = S_DONE;
        S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // start_ready drops under flush so a flush-cycle request is never handshaken.
  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    alu_op      = ALU_NOP;
    alu_a       = '0;
    alu_b       = '0;
    case (r_state)
      S_IDLE: start_ready = !flush;
      S_RUN: begin
        busy   = 1'b1;
        alu_op = ALU_ADD;
        alu_a  = r_acc;
        alu_b  = r_mplier[0] ? r_mcand : '0;
      end
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign prod_hi = r_acc;
  assign prod_lo = r_mplier;

  // The ALU carry becomes the new acc MSB, so bit DATA_WIDTH of each partial sum survives the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_mcand  <= op_a;
      r_mplier <= w_zero ? '0 : op_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == S_RUN) begin
      {r_acc, r_mplier} <= {alu_carry, alu_result, r_mplier[DATA_WIDTH-1:1]};
      if (!w_last) r_count <= r_count + CW'(1);
    end
  end

endmodule
